sccb_write_arbiter: RTL and testbench

- Shares one i2c_module SCCB write engine between two requesters: requester 0 is the boot-time camera init sequencer, requester 1 is the runtime tuning logic (exposure, white balance, mirror/flip).
- Each accepted request is one OV2640 register write.
- The arbiter programs the engine's register file (slave address, register address, data, control go), tracks the busy/ready handshake and retries on NACK.
- It returns a per-requester done/error pulse.

---
 rtl/sccb_write_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sccb_write_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_write_arbiter.sv
// Two-requester arbiter in front of a shared SCCB write engine: loads slave/reg/data, kicks the
// engine, retries on NACK or timeout. Optional bank-select prefix writes under SCCB_BANK_CACHE_EN.
module sccb_write_arbiter #(
    parameter logic [7:0] SLAVE_ADDR = 8'h60,
    parameter int         MAX_RETRY  = 3,
    parameter int         TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_reg,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_bank,
    output logic [1:0]  req_ready,
    output logic [1:0]  done,
    output logic        err,
    output logic        busy,
    output logic [2:0]  i2c_address,
    output logic [7:0]  i2c_writedata,
    output logic        i2c_write,
    input  logic        i2c_ready,
    input  logic        i2c_success
);

`ifdef SCCB_BANK_CACHE_EN
    localparam bit BANK_CACHE = 1'b1;
`else
    localparam bit BANK_CACHE = 1'b0;
`endif
    localparam int               TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LD_SLV, LD_REG, LD_DAT, GO, WAIT_BUSY, WAIT_DONE, RESP
    } state_t;

    state_t           state;
    logic             rr_ptr;
    logic             gnt;
    logic [7:0]       reg_q;
    logic [7:0]       data_q;
    logic             bank_q;
    logic [3:0]       retry_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             fail_q;
    logic             prefix;
    logic             cache_vld;
    logic             cache_bank;

    logic             pick;
    logic [7:0]       pick_reg;
    logic [7:0]       pick_data;
    logic             need_prefix;
    logic             tmo_hit;
    logic             attempt_end;
    logic             attempt_ok;
    logic             can_retry;

    always_comb begin
        pick = rr_ptr;
        if (req_valid == 2'b01)
            pick = 1'b0;
        else if (req_valid == 2'b10)
            pick = 1'b1;
        pick_reg  = pick ? req_reg[15:8]  : req_reg[7:0];
        pick_data = pick ? req_data[15:8] : req_data[7:0];
    end

    // A direct write to 0xFF already selects the bank, so it never needs a prefix.
    assign need_prefix = BANK_CACHE && (reg_q != 8'hFF) && (!cache_vld || (cache_bank != bank_q));
    assign tmo_hit     = (tmo_cnt >= TMO_LAST);
    assign attempt_ok  = (state == WAIT_DONE) && i2c_ready && i2c_success;
    assign attempt_end = ((state == WAIT_BUSY) && i2c_ready && tmo_hit) ||
                         ((state == WAIT_DONE) && (i2c_ready || tmo_hit));
    assign can_retry   = (int'(retry_cnt) < MAX_RETRY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            gnt           <= 1'b0;
            reg_q         <= '0;
            data_q        <= '0;
            bank_q        <= 1'b0;
            retry_cnt     <= '0;
            tmo_cnt       <= '0;
            fail_q        <= 1'b0;
            prefix        <= 1'b0;
            cache_vld     <= 1'b0;
            cache_bank    <= 1'b0;
            req_ready     <= '0;
            done          <= '0;
            err           <= 1'b0;
            busy          <= 1'b0;
            i2c_address   <= '0;
            i2c_writedata <= '0;
            i2c_write     <= 1'b0;
        end else begin
            req_ready <= '0;
            done      <= '0;
            err       <= 1'b0;
            i2c_write <= 1'b0;
            if (ce) begin
                case (state)
                    IDLE: if (|req_valid) begin
                        gnt             <= pick;
                        req_ready[pick] <= 1'b1;
                        reg_q           <= pick_reg;
                        data_q          <= pick_data;
                        bank_q          <= req_bank[pick];
                        busy            <= 1'b1;
                        fail_q          <= 1'b0;
                        retry_cnt       <= '0;
                        prefix          <= 1'b0;
                        if (BANK_CACHE && (pick_reg == 8'hFF)) begin
                            cache_vld  <= 1'b1;
                            cache_bank <= pick_data[0];
                        end
                        i2c_address   <= 3'd1;
                        i2c_writedata <= SLAVE_ADDR;
                        i2c_write     <= 1'b1;
                        state         <= LD_SLV;
                    end
                    LD_SLV: begin
                        prefix        <= need_prefix;
                        i2c_address   <= 3'd2;
                        i2c_writedata <= need_prefix ? 8'hFF : reg_q;
                        i2c_write     <= 1'b1;
                        state         <= LD_REG;
                    end
                    LD_REG: begin
                        i2c_address   <= 3'd3;
                        i2c_writedata <= prefix ? {7'b0, bank_q} : data_q;
                        i2c_write     <= 1'b1;
                        state         <= LD_DAT;
                    end
                    LD_DAT: begin
                        i2c_address   <= 3'd0;
                        i2c_writedata <= 8'h01;
                        i2c_write     <= 1'b1;
                        state         <= GO;
                    end
                    GO: begin
                        i2c_address   <= 3'd0;
                        i2c_writedata <= 8'h00;
                        tmo_cnt       <= '0;
                        state         <= WAIT_BUSY;
                    end
                    WAIT_BUSY, WAIT_DONE: begin
                        if (!attempt_end) begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                            if ((state == WAIT_BUSY) && !i2c_ready)
                                state <= WAIT_DONE;
                        end else if (attempt_ok && prefix) begin
                            // Bank selected: run the requested write with a fresh retry budget.
                            prefix        <= 1'b0;
                            cache_vld     <= 1'b1;
                            cache_bank    <= bank_q;
                            retry_cnt     <= '0;
                            i2c_address   <= 3'd2;
                            i2c_writedata <= reg_q;
                            i2c_write     <= 1'b1;
                            state         <= LD_REG;
                        end else if (attempt_ok) begin
                            state <= RESP;
                        end else if (can_retry) begin
                            retry_cnt     <= retry_cnt + 4'd1;
                            i2c_address   <= 3'd2;
                            i2c_writedata <= prefix ? 8'hFF : reg_q;
                            i2c_write     <= 1'b1;
                            state         <= LD_REG;
                        end else begin
                            fail_q    <= 1'b1;
                            prefix    <= 1'b0;
                            cache_vld <= 1'b0;
                            state     <= RESP;
                        end
                    end
                    RESP: begin
                        done[gnt] <= 1'b1;
                        err       <= fail_q;
                        busy      <= 1'b0;
                        rr_ptr    <= ~gnt;
                        retry_cnt <= '0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Randomized bench for sccb_write_arbiter: behavioural engine plus a transaction-level model of
// grant order, engine write sequence, retry outcome and bank cache (SCCB_BANK_CACHE_EN).
module tb_sccb_write_arbiter;
    localparam logic [7:0] SLAVE    = 8'h60;
    localparam int         MAXR     = 3;
    localparam int         TMO      = 24;
    localparam int         O_ACK    = 0;
    localparam int         O_NACK   = 1;
    localparam int         O_TMO    = 2;
    localparam int         O_HANG   = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic [1:0]  req_valid;
    logic [15:0] req_reg;
    logic [15:0] req_data;
    logic [1:0]  req_bank;
    logic [1:0]  req_ready;
    logic [1:0]  done;
    logic        err;
    logic        busy;
    logic [2:0]  i2c_address;
    logic [7:0]  i2c_writedata;
    logic        i2c_write;
    logic        i2c_ready;
    logic        i2c_success;

    sccb_write_arbiter #(.SLAVE_ADDR(SLAVE), .MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .req_valid(req_valid), .req_reg(req_reg),
        .req_data(req_data), .req_bank(req_bank), .req_ready(req_ready), .done(done), .err(err),
        .busy(busy), .i2c_address(i2c_address), .i2c_writedata(i2c_writedata),
        .i2c_write(i2c_write), .i2c_ready(i2c_ready), .i2c_success(i2c_success)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int plan[$];
    int pend[$];
    logic [15:0] eng_log[$];
    int eng_phase, eng_cnt, eng_mode, ce_wait, gap, tmo_gap;
    bit last_tmo;
    bit m_rr, m_cvld, m_cbank;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit need_pre(input logic [7:0] r, input bit b);
        bit p;
        p = 1'b0;
`ifdef SCCB_BANK_CACHE_EN
        p = (r != 8'hFF) && (!m_cvld || (m_cbank != b));
`endif
        return p;
    endfunction

    // Engine model and clock-enable generator, both on the falling edge.
    initial begin
        i2c_ready = 1'b1; i2c_success = 1'b0; ce = 1'b0;
        eng_phase = 0; eng_cnt = 0; eng_mode = 0; ce_wait = 0; gap = 0; last_tmo = 1'b0;
        forever begin
            @(negedge clk);
            if (ce) gap++;
            if (!reset_n) begin
                eng_phase = 0; i2c_ready = 1'b1; i2c_success = 1'b0;
            end else if (i2c_write) begin
                eng_log.push_back({5'b0, i2c_address, i2c_writedata});
                if (i2c_address == 3'd1) last_tmo = 1'b0;
                if (i2c_address == 3'd2 && last_tmo) tmo_gap = gap;
                if (i2c_address == 3'd0) begin
                    gap = 0;
                    eng_mode = (plan.size() > 0) ? plan.pop_front() : O_ACK;
                    last_tmo = (eng_mode == O_TMO);
                    i2c_success = 1'b0;
                    eng_phase = (eng_mode == O_TMO) ? 0 : 1;
                    eng_cnt = 2;
                end
            end else if (eng_phase == 1) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    i2c_ready = 1'b0; eng_phase = 2; eng_cnt = $urandom_range(8, 14);
                end
            end else if (eng_phase == 2 && eng_mode != O_HANG) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    i2c_ready = 1'b1; i2c_success = (eng_mode == O_ACK); eng_phase = 0;
                end
            end
            if (ce_wait == 0) begin
                ce = 1'b1; ce_wait = $urandom_range(0, 2);
            end else begin
                ce = 1'b0; ce_wait--;
            end
        end
    end

    // One full transaction for whichever requester the arbitration rule selects.
    task automatic serve();
        bit g, b, pre, e;
        logic [7:0] r, d;
        int n, o, waited;
        logic [15:0] exp_q[$];
        g = (req_valid == 2'b01) ? 1'b0 : (req_valid == 2'b10) ? 1'b1 : m_rr;
        r = g ? req_reg[15:8] : req_reg[7:0];
        d = g ? req_data[15:8] : req_data[7:0];
        b = req_bank[g];
        pre = need_pre(r, b);
        n = MAXR + 1; e = 1'b1;
        for (int i = 0; i <= MAXR; i++) begin
            o = (i < pend.size()) ? pend[i] : O_ACK;
            if (o == O_ACK) begin n = i + 1; e = 1'b0; break; end
        end
        plan.delete();
        if (pre) plan.push_back(O_ACK);
        for (int i = 0; i < n; i++) plan.push_back((i < pend.size()) ? pend[i] : O_ACK);
        eng_log.delete();
        waited = 0;
        do begin @(negedge clk); waited++; end while (req_ready == 2'b00 && waited < 300);
        if (req_ready == 2'b00) begin chk("grant_wait", 0, 1); return; end
        chk("grant", req_ready, g ? 2'b10 : 2'b01);
        chk("busy_acc", busy, 1);
        req_valid[g] = 1'b0;
`ifdef SCCB_BANK_CACHE_EN
        if (r == 8'hFF) begin m_cvld = 1'b1; m_cbank = d[0]; end
`endif
        waited = 0;
        do begin @(negedge clk); waited++; end while (done == 2'b00 && waited < 6000);
        if (done == 2'b00) begin chk("done_wait", 0, 1); return; end
        chk("done", done, g ? 2'b10 : 2'b01);
        chk("err", err, e);
        chk("busy_done", busy, 0);
        exp_q.push_back({5'b0, 3'd1, SLAVE});
        if (pre) begin
            exp_q.push_back({5'b0, 3'd2, 8'hFF});
            exp_q.push_back({5'b0, 3'd3, 7'b0, b});
            exp_q.push_back({5'b0, 3'd0, 8'h01});
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({5'b0, 3'd2, r});
            exp_q.push_back({5'b0, 3'd3, d});
            exp_q.push_back({5'b0, 3'd0, 8'h01});
        end
        chk("log_len", eng_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < eng_log.size(); i++)
            chk($sformatf("log[%0d]", i), eng_log[i], exp_q[i]);
        m_rr = ~g;
        if (pre) begin m_cvld = 1'b1; m_cbank = b; end
        if (e) m_cvld = 1'b0;
    endtask

    function automatic int rand_out();
        int v;
        v = $urandom_range(0, 19);
        return (v < 12) ? O_ACK : (v < 17) ? O_NACK : O_TMO;
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

    initial begin
        int waited, seen;
        reset_n = 1'b0; req_valid = 2'b00; req_reg = '0; req_data = '0; req_bank = 2'b00;
        m_rr = 1'b0; m_cvld = 1'b0; m_cbank = 1'b0; tmo_gap = -1;
        repeat (5) @(negedge clk);
        chk("rst_outs", {req_ready, done, err, busy, i2c_address, i2c_writedata, i2c_write}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Contention straight out of reset, then a lone requester 0 write.
        req_reg = 16'h3412; req_data = 16'h7755; req_valid = 2'b11;
        pend = {O_ACK}; serve();
        pend = {O_ACK}; serve();
        req_reg[7:0] = 8'h12; req_data[7:0] = 8'h80; req_valid = 2'b01;
        pend = {O_ACK}; serve();

        // NACK retries and timeouts.
        req_valid = 2'b10; pend = {O_NACK, O_NACK, O_ACK}; serve();
        req_valid = 2'b01; pend = {O_NACK, O_NACK, O_NACK, O_NACK}; serve();
        tmo_gap = -1;
        req_valid = 2'b10; pend = {O_TMO, O_ACK}; serve();
        chk("tmo_gap", (tmo_gap >= TMO && tmo_gap <= TMO + 2), 1);
        req_valid = 2'b01; pend = {O_TMO, O_TMO, O_TMO, O_TMO}; serve();

        for (int k = 0; k < 20; k++) begin
            int pat;
            pat = $urandom_range(1, 3);
            req_reg = 16'($urandom); req_data = 16'($urandom); req_bank = 2'($urandom);
            pend.delete();
            for (int i = 0; i <= MAXR; i++) pend.push_back(rand_out());
            req_valid = pat[1:0];
            serve();
            if (pat == 3) begin
                pend.delete();
                for (int i = 0; i <= MAXR; i++) pend.push_back(rand_out());
                serve();
            end
        end

        // Reset while the engine is mid-transfer.
        req_reg[7:0] = 8'h3A; req_data[7:0] = 8'h55; req_bank = 2'b00;
        plan.delete();
        if (need_pre(8'h3A, 1'b0)) plan.push_back(O_ACK);
        plan.push_back(O_HANG);
        req_valid = 2'b01;
        waited = 0;
        do begin @(negedge clk); waited++; end while (req_ready == 2'b00 && waited < 300);
        chk("rst_grant", req_ready, 2'b01);
        req_valid = 2'b00;
        waited = 0;
        do begin @(negedge clk); waited++; end while (!(i2c_ready == 1'b0 && eng_mode == O_HANG) && waited < 600);
        chk("hang_reached", (i2c_ready == 1'b0 && eng_mode == O_HANG), 1);
        repeat (6) @(negedge clk);
        chk("busy_pre_rst", busy, 1);
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_outs", {req_ready, done, err, busy, i2c_address, i2c_writedata, i2c_write}, 0);
        m_rr = 1'b0; m_cvld = 1'b0; plan.delete();
        seen = 0;
        repeat (4) begin @(negedge clk); if (done != 2'b00) seen++; end
        reset_n = 1'b1;
        repeat (30) begin @(negedge clk); if (done != 2'b00) seen++; end
        chk("no_done_after_rst", seen, 0);
        req_reg = 16'h2211; req_data = 16'h4433; req_bank = 2'b00; req_valid = 2'b11;
        pend = {O_ACK}; serve();
        pend = {O_ACK}; serve();

        // Bank sequence 1, 1, 0 on requester 0.
        req_reg[7:0] = 8'h04; req_data[7:0] = 8'h20;
        req_bank = 2'b01; req_valid = 2'b01; pend = {O_ACK}; serve();
        req_bank = 2'b01; req_valid = 2'b01; pend = {O_ACK}; serve();
        req_bank = 2'b00; req_valid = 2'b01; pend = {O_ACK}; serve();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
